// File: rtl/max_find_arbiter.sv
// Two-requester round-robin arbiter feeding a signed 4-bit max-element scan.
// Define MAXF_EARLY_EXIT_EN to end the scan as soon as the running max hits +7.
module max_find_arbiter #(
    parameter bit FIRST_PRIO = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic [63:0] vec0,
    input  logic [63:0] vec1,
    output logic        gnt0,
    output logic        gnt1,
    output logic        busy,
    output logic        done,
    output logic        done_id,
    output logic [3:0]  max_index,
    output logic [3:0]  max_value
);

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } state_t;

    state_t state_q, state_n;

    logic [63:0]       vec_q, vec_n;
    logic signed [3:0] max_q, max_n;
    logic [3:0]        maxi_q, maxi_n;
    logic [3:0]        i_q, i_n;
    logic              last_q, last_n;
    logic              owner_q, owner_n;

    logic              gnt0_n, gnt1_n;
    logic              done_n, done_id_n;
    logic [3:0]        max_index_n, max_value_n;

    logic              win;
    logic              last_elem;
    logic signed [3:0] cand;

    assign cand = $signed(vec_q[{i_q, 2'b00} +: 4]);
    assign busy = (state_q != IDLE);

    always_comb begin
        state_n     = state_q;
        vec_n       = vec_q;
        max_n       = max_q;
        maxi_n      = maxi_q;
        i_n         = i_q;
        last_n      = last_q;
        owner_n     = owner_q;
        gnt0_n      = 1'b0;
        gnt1_n      = 1'b0;
        done_n      = 1'b0;
        done_id_n   = done_id;
        max_index_n = max_index;
        max_value_n = max_value;
        win         = 1'b0;
        last_elem   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    // Under contention the side not served last wins.
                    win     = (req0 && req1) ? ~last_q : req1;
                    vec_n   = win ? vec1 : vec0;
                    max_n   = $signed(vec_n[3:0]);
                    maxi_n  = 4'd0;
                    i_n     = 4'd1;
                    last_n  = win;
                    owner_n = win;
                    gnt0_n  = ~win;
                    gnt1_n  = win;
                    state_n = SCAN;
`ifdef MAXF_EARLY_EXIT_EN
                    if (vec_n[3:0] == 4'd7) begin
                        state_n     = DONE;
                        done_n      = 1'b1;
                        done_id_n   = win;
                        max_index_n = 4'd0;
                        max_value_n = 4'd7;
                    end
`endif
                end
            end
            SCAN: begin
                // Strict compare keeps the first occurrence on ties.
                if (cand > max_q) begin
                    max_n  = cand;
                    maxi_n = i_q;
                end
                last_elem = (i_q == 4'd15);
`ifdef MAXF_EARLY_EXIT_EN
                last_elem = last_elem || (max_n == 4'sd7);
`endif
                if (last_elem) begin
                    state_n     = DONE;
                    done_n      = 1'b1;
                    done_id_n   = owner_q;
                    max_index_n = maxi_n;
                    max_value_n = max_n;
                end else begin
                    i_n = i_q + 4'd1;
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            vec_q     <= '0;
            max_q     <= '0;
            maxi_q    <= '0;
            i_q       <= '0;
            last_q    <= ~FIRST_PRIO;
            owner_q   <= 1'b0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            max_index <= '0;
            max_value <= '0;
        end else begin
            state_q   <= state_n;
            vec_q     <= vec_n;
            max_q     <= max_n;
            maxi_q    <= maxi_n;
            i_q       <= i_n;
            last_q    <= last_n;
            owner_q   <= owner_n;
            gnt0      <= gnt0_n;
            gnt1      <= gnt1_n;
            done      <= done_n;
            done_id   <= done_id_n;
            max_index <= max_index_n;
            max_value <= max_value_n;
        end
    end

endmodule
